// File: rtl/rf_wport_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package rf_wport_sched_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    // Starvation tracker states for a refused MDU result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } starve_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Destination-register scoreboard for in-flight MDU operations.
// Tracks which registers await an MDU write and how many ops are outstanding.
module rf_scoreboard
    import rf_wport_sched_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic                  acc_valid,
    input  logic [REG_ADDR_W-1:0] acc_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    input  logic [REG_ADDR_W-1:0] q_wb,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  busy_wb,
    output logic                  out_zero
);

    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    outstanding;
    logic                iss_fire;

    // Issue permission and lookups come from registered state only; x0 is never set.
    always_comb begin
        iss_ready = !rst && !busy[iss_rd] && (outstanding < OUT_MAX);
        iss_fire  = iss_valid && iss_ready;
        busy_rs1  = busy[q_rs1];
        busy_rs2  = busy[q_rs2];
        busy_wb   = busy[q_wb];
        out_zero  = (outstanding == '0);
    end

    // Busy bits and outstanding count; a set on issue lands after a clear on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            if (acc_valid)
                busy[acc_rd] <= 1'b0;
            if (iss_fire && (iss_rd != '0))
                busy[iss_rd] <= 1'b1;
            case ({iss_fire, acc_valid})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/rf_wport_sched.sv
// Register-file write-port scheduler: WB has priority over the MDU, a
// scoreboard exposes pending MDU destinations, and a starvation tracker
// requests a pipeline stall when the MDU is refused for too long.
module rf_wport_sched
    import rf_wport_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_rd,
    input  logic [31:0] pipe_wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        sb_err
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    starve_state_t      state;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_cnt_nxt;
    logic               pipe_act;
    logic               mdu_refused;
    logic               busy_wb;
    logic               out_zero;

    // Write-port arbitration: WB wins; WB to x0 leaves the port free for the MDU.
    always_comb begin
        pipe_act  = pipe_wb_valid && (pipe_wb_rd != '0);
        mdu_ready = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (!rst) begin
            if (pipe_act) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_wb_rd;
                rf_wdata = pipe_wb_data;
            end else if (mdu_valid) begin
                mdu_ready = 1'b1;
                rf_we     = (mdu_rd != '0);
                rf_waddr  = mdu_rd;
                rf_wdata  = mdu_data;
            end
        end
        mdu_refused    = mdu_valid && !mdu_ready;
        starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end

    rf_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .acc_valid (mdu_ready),
        .acc_rd    (mdu_rd),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .q_wb      (pipe_wb_rd),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_wb   (busy_wb),
        .out_zero  (out_zero)
    );

    // Sticky error: WB overwriting an MDU-owned register, or an unexpected MDU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_err <= 1'b0;
        else if ((pipe_act && busy_wb) || (mdu_ready && out_zero))
            sb_err <= 1'b1;
    end

    // Starvation tracker: counts refused cycles and holds stall_req until acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_refused) begin
                        starve_cnt <= CNT_W'(1);
                        if (STARVE_LIM == CNT_W'(1)) begin
                            state     <= FORCE;
                            stall_req <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!mdu_refused) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= starve_cnt_nxt;
                        if (starve_cnt_nxt == STARVE_LIM) begin
                            state     <= FORCE;
                            stall_req <= 1'b1;
                        end
                    end
                end
                FORCE: begin
                    if (!mdu_refused) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                        stall_req  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                    stall_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Directed self-checking bench for rf_wport_sched.
module tb_rf_wport_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_sched #(
        .STARVE_MAX      (4),
        .MAX_OUTSTANDING (4),
        .CNT_W           (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wb_valid (pipe_wb_valid),
        .pipe_wb_rd    (pipe_wb_rd),
        .pipe_wb_data  (pipe_wb_data),
        .mdu_valid     (mdu_valid),
        .mdu_rd        (mdu_rd),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .iss_ready     (iss_ready),
        .q_rs1         (q_rs1),
        .q_rs2         (q_rs2),
        .busy_rs1      (busy_rs1),
        .busy_rs2      (busy_rs2),
        .stall_req     (stall_req),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .sb_err        (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        iss_valid = 1'b0; iss_rd = '0; q_rs1 = '0; q_rs2 = '0;

        // Reset state
        #2;
        check("rst_rf_we", rf_we, 0);
        check("rst_mdu_ready", mdu_ready, 0);
        check("rst_iss_ready", iss_ready, 0);
        check("rst_stall", stall_req, 0);
        check("rst_sb_err", sb_err, 0);
        check("rst_busy1", busy_rs1, 0);
        step(); step();
        rst = 1'b0;

        // Issue rd=7 then complete it
        iss_valid = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7;
        #1;
        check("iss7_ready", iss_ready, 1);
        check("iss7_busy_before", busy_rs1, 0);
        step();
        iss_valid = 1'b0;
        #1;
        check("iss7_busy_after", busy_rs1, 1);
        check("iss7_waw_ready", iss_ready, 0);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hDEADBEEF;
        #1;
        check("cpl7_we", rf_we, 1);
        check("cpl7_waddr", rf_waddr, 7);
        check("cpl7_wdata", rf_wdata, 32'hDEADBEEF);
        check("cpl7_ready", mdu_ready, 1);
        step();
        mdu_valid = 1'b0;
        #1;
        check("cpl7_busy_clr", busy_rs1, 0);

        // Contention: WB rd=3 vs MDU rd=9
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h0000_0033;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h0000_0099;
        #1;
        check("cont_we", rf_we, 1);
        check("cont_waddr", rf_waddr, 3);
        check("cont_wdata", rf_wdata, 32'h33);
        check("cont_mdu_ready", mdu_ready, 0);
        step();
        pipe_wb_valid = 1'b0;
        #1;
        check("cont_mdu_waddr", rf_waddr, 9);
        check("cont_mdu_wdata", rf_wdata, 32'h99);
        check("cont_mdu_ready2", mdu_ready, 1);
        step();
        mdu_valid = 1'b0; q_rs1 = 5'd9;
        #1;
        check("cont_stall", stall_req, 0);
        check("cont_busy9", busy_rs1, 0);
        check("cont_sb_err", sb_err, 0);

        // Starvation: WB every cycle, MDU rd=10 waiting
        iss_valid = 1'b1; iss_rd = 5'd10;
        step();
        iss_valid = 1'b0;
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h1;
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA5A5A5A5;
        step(); step(); step();
        check("starve_3", stall_req, 0);
        step();
        check("starve_4", stall_req, 1);
        pipe_wb_valid = 1'b0;
        #1;
        check("starve_acc_ready", mdu_ready, 1);
        check("starve_acc_waddr", rf_waddr, 10);
        check("starve_hold", stall_req, 1);
        step();
        mdu_valid = 1'b0;
        check("starve_drop", stall_req, 0);

        // Limits: four distinct issues fill the scoreboard
        iss_valid = 1'b1;
        iss_rd = 5'd4; #1; check("lim_iss4", iss_ready, 1); step();
        iss_rd = 5'd5; #1; check("lim_iss5", iss_ready, 1); step();
        iss_rd = 5'd6; #1; check("lim_iss6", iss_ready, 1); step();
        iss_rd = 5'd8; #1; check("lim_iss8", iss_ready, 1); step();
        iss_valid = 1'b0;
        iss_rd = 5'd4; q_rs1 = 5'd4; q_rs2 = 5'd8;
        #1;
        check("lim_waw4", iss_ready, 0);
        check("lim_busy4", busy_rs1, 1);
        check("lim_busy8", busy_rs2, 1);
        iss_rd = 5'd11;
        #1;
        check("lim_full", iss_ready, 0);
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h44;
        #1;
        check("lim_cpl4", mdu_ready, 1);
        step();
        mdu_valid = 1'b0;
        #1;
        check("lim_after_cpl", iss_ready, 1);
        check("lim_busy4_clr", busy_rs1, 0);
        mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h55;
        iss_valid = 1'b1; iss_rd = 5'd11;
        #1;
        check("lim_same_iss", iss_ready, 1);
        check("lim_same_acc", mdu_ready, 1);
        step();
        mdu_valid = 1'b0; iss_valid = 1'b0;
        iss_rd = 5'd13; q_rs1 = 5'd11; q_rs2 = 5'd5;
        #1;
        check("lim_same_ready", iss_ready, 1);
        check("lim_busy11", busy_rs1, 1);
        check("lim_busy5_clr", busy_rs2, 0);
        iss_valid = 1'b1; iss_rd = 5'd12;
        step();
        iss_valid = 1'b0; iss_rd = 5'd13;
        #1;
        check("lim_refull", iss_ready, 0);

        // Errors and x0
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd12; pipe_wb_data = 32'hC;
        step();
        pipe_wb_valid = 1'b0;
        #1;
        check("err_set", sb_err, 1);
        step();
        check("err_sticky", sb_err, 1);
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd0; pipe_wb_data = 32'hFFFF;
        mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
        #1;
        check("x0wb_mdu_ready", mdu_ready, 1);
        check("x0wb_we", rf_we, 1);
        check("x0wb_waddr", rf_waddr, 6);
        check("x0wb_wdata", rf_wdata, 32'h66);
        step();
        pipe_wb_valid = 1'b0;
        mdu_rd = 5'd0; mdu_data = 32'h77; q_rs1 = 5'd0;
        #1;
        check("x0mdu_ready", mdu_ready, 1);
        check("x0mdu_we", rf_we, 0);
        step();
        mdu_valid = 1'b0;
        #1;
        check("x0_busy", busy_rs1, 0);
        check("idle_we", rf_we, 0);
        check("idle_waddr", rf_waddr, 0);
        check("idle_wdata", rf_wdata, 0);

        // Reset mid-run with busy[5] set and stall_req asserted
        iss_valid = 1'b1; iss_rd = 5'd5; q_rs1 = 5'd5;
        step();
        iss_valid = 1'b0;
        #1;
        check("mid_busy5", busy_rs1, 1);
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h3;
        mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_data = 32'h88;
        step(); step(); step(); step();
        check("mid_stall", stall_req, 1);
        iss_valid = 1'b1; iss_rd = 5'd13;
        #1;
        check("mid_iss_ready", iss_ready, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy5", busy_rs1, 0);
        check("mid_rst_stall", stall_req, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_mdu_ready", mdu_ready, 0);
        check("mid_rst_iss_ready", iss_ready, 0);
        check("mid_rst_sb_err", sb_err, 0);
        iss_valid = 1'b0; pipe_wb_valid = 1'b0; mdu_valid = 1'b0;
        step();
        rst = 1'b0;
        q_rs2 = 5'd8;
        #1;
        check("post_rst_busy8", busy_rs2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
